line_fill_buffer: RTL and testbench
===================================

Name: line_fill_buffer

Overview:
- Fetches one full cache line from memory over an AXI4 read burst when the cache controller reports a miss (read miss or write-allocate).
- Uses critical-word-first WRAP bursts. The requested word is returned early so the pipeline can resume before the rest of the line arrives.
- Sits between the cache controller (LB_Enable / LB_FirstWord / LB_Completed handshake) and the AXI read channels.
- Presents the assembled line for the controller's line-write into the cache data array.

Parameters:
- WORDS_PER_LINE, 8, 32-bit words per cache line (line = 32 bytes, byte offset bits [4:0]).
- ADDR_W, 32, byte address width.

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- LB_Enable  in  1  level request from controller; held high until Completed is seen
- MissAddress  in  ADDR_W  byte address of missing word; sampled on fill start
- LineAddress  out  ADDR_W  latched line-aligned address of the fill in progress (low 5 bits zero)
- LB_FirstWord  out  1  one-cycle pulse: critical word available
- CrtWordData  out  32  critical word; valid from the LB_FirstWord cycle until the next fill start
- LB_Completed  out  1  whole line assembled
- LineData  out  32*WORDS_PER_LINE  word i at bits [32i+31:32i]; valid while LB_Completed=1
- Busy  out  1  fill or drain in progress
- Error  out  1  sticky: bad RRESP or RLAST mismatch during the current fill; cleared on next fill start
- M_ARADDR  out  ADDR_W  AXI read address
- M_ARLEN  out  8  constant WORDS_PER_LINE-1
- M_ARSIZE  out  3  constant 3'b010
- M_ARBURST  out  2  constant 2'b10 (WRAP)
- M_ARVALID  out  1  AXI
- M_ARREADY  in  1  AXI
- M_RDATA  in  32  AXI
- M_RRESP  in  2  AXI
- M_RLAST  in  1  AXI
- M_RVALID  in  1  AXI
- M_RREADY  out  1  AXI

Behaviour:
- Reset values: state IDLE; all 1-bit outputs 0; LineAddress, CrtWordData, M_ARADDR and LineData all 0.
- States: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE:
  - On LB_Enable=1, latch MissAddress.
  - M_ARADDR <= {MissAddress[ADDR_W-1:2],2'b00}; LineAddress <= {MissAddress[ADDR_W-1:5],5'b0}.
  - Beat index <= MissAddress[4:2]; beat counter <= 0; Error <= 0; Busy <= 1.
  - Next state ADDR.
- ADDR:
  - M_ARVALID=1, held with stable address until M_ARREADY=1; then ARVALID <= 0 and go to DATA.
  - ARVALID is never dropped before the handshake, even if LB_Enable falls.
- DATA:
  - M_RREADY=1. Each beat with M_RVALID=1 writes M_RDATA to word[index].
  - index <= index+1 mod WORDS_PER_LINE (3-bit wrap 7->0); counter++.
  - First beat (counter=0): CrtWordData <= RDATA; LB_FirstWord pulses high for exactly one cycle, the cycle after the beat is accepted.
  - M_RRESP != 0 on any beat sets Error.
  - M_RLAST=1 with counter != WORDS_PER_LINE-1, or RLAST=0 on the final beat, sets Error.
  - Completion is always at beat WORDS_PER_LINE; an early RLAST does not end the fill.
  - Final beat accepted: go to DONE; LB_Completed=1 from the next cycle.
- Latencies:
  - First word: LB_FirstWord occurs 1 cycle after the first R handshake.
  - LB_Completed occurs 1 cycle after the last R handshake.
  - With an always-ready slave: ARVALID in cycle 1 after enable, first R earliest cycle 2, FirstWord cycle 3.
- DONE:
  - LB_Completed and Busy stay high while LB_Enable=1.
  - When LB_Enable=0: next cycle LB_Completed=0, Busy=0, state IDLE. LineData/LineAddress hold their values.
  - A new fill starts only from IDLE, so back-to-back misses have at least 1 idle cycle between fills.
- Abort: LB_Enable=0 while in ADDR or DATA:
  - Finish the AR handshake if pending, then DRAIN.
  - DRAIN: RREADY=1, accept and discard the remaining beats. Later beats are still written into word[] so LineData stays coherent, but no further FirstWord and no Completed.
  - After the last beat go to IDLE, Busy=0.
  - LB_Enable re-asserted during DRAIN is ignored until IDLE.
- FirstWord and final beat in the same cycle (WORDS_PER_LINE=1): LB_FirstWord and LB_Completed both assert on the next cycle.
- LB_FirstWord never asserts in ADDR, DONE or IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The AXI slave must be reset with the same Rst; outstanding beats are not tracked.

Test Plan:
- Aligned miss, MissAddress=0x0000_1000, always-ready slave returning 0xA0..0xA7 -> ARADDR=0x1000, ARLEN=7, ARBURST=2; FirstWord with CrtWordData=0xA0; LineData word0=0xA0..word7=0xA7; Completed 1 cycle after 8th beat.
- Critical-word-first, MissAddress=0x0000_201C, beats B0..B7 -> ARADDR=0x201C; CrtWordData=B0 stored at word7; B1 at word0 ... B7 at word6; LineAddress=0x2000.
- Backpressure: ARREADY delayed 4 cycles, RVALID toggled every other cycle -> ARVALID and ARADDR stable for 5 cycles; exactly 8 word writes; single FirstWord pulse; Completed after 8th beat only.
- Handshake: hold LB_Enable 3 cycles after Completed, then drop -> Completed high 3+ cycles, low and Busy=0 one cycle after drop; immediate re-enable with 0x3000 starts a new fill with Error cleared.
- Abort: drop LB_Enable after beat 2 -> remaining 6 beats accepted with RREADY=1, no Completed, Busy falls after 8th beat; Error with RRESP=2'b10 on beat 4 of a normal fill -> Error=1, Completed still asserted.
- Reset mid-fill at beat 5 -> next cycle all outputs 0, state IDLE; new fill proceeds normally.

Source files
------------

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: critical-word-first AXI4 WRAP line fill
// for the cache miss path, with early critical-word return.
module line_fill_buffer #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W = 32
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        LB_Enable,
  input  logic [ADDR_W-1:0]           MissAddress,
  output logic [ADDR_W-1:0]           LineAddress,
  output logic                        LB_FirstWord,
  output logic [31:0]                 CrtWordData,
  output logic                        LB_Completed,
  output logic [32*WORDS_PER_LINE-1:0] LineData,
  output logic                        Busy,
  output logic                        Error,
  output logic [ADDR_W-1:0]           M_ARADDR,
  output logic [7:0]                  M_ARLEN,
  output logic [2:0]                  M_ARSIZE,
  output logic [1:0]                  M_ARBURST,
  output logic                        M_ARVALID,
  input  logic                        M_ARREADY,
  input  logic [31:0]                 M_RDATA,
  input  logic [1:0]                  M_RRESP,
  input  logic                        M_RLAST,
  input  logic                        M_RVALID,
  output logic                        M_RREADY
);

  localparam int IW =
    (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LOFF = $clog2(4 * WORDS_PER_LINE);
  localparam logic [IW-1:0] LAST = IW'(WORDS_PER_LINE - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [IW-1:0] cnt;
  logic [IW-1:0] startIdx;
  logic          abortReq;
  logic          beat;
  logic          lastBeat;
  logic          beatErr;
  logic          live;

  assign M_ARLEN   = 8'(WORDS_PER_LINE - 1);
  assign M_ARSIZE  = 3'b010;
  assign M_ARBURST = 2'b10;
  assign M_RREADY  = (state == DATA) || (state == DRAIN);

  assign startIdx = IW'(MissAddress >> 2) & LAST;
  assign beat     = M_RVALID && M_RREADY;
  assign lastBeat = (cnt == LAST);
  assign beatErr  = (M_RRESP != 2'b00) || (M_RLAST != lastBeat);
  // A beat only counts toward FirstWord/Completed while the
  // controller still wants the line; otherwise it is drained.
  assign live     = (state == DATA) && LB_Enable;

  // Fill sequencer: AR issue, beat assembly, handshake and drain
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      abortReq     <= 1'b0;
      LineAddress  <= '0;
      M_ARADDR     <= '0;
      M_ARVALID    <= 1'b0;
      LB_FirstWord <= 1'b0;
      LB_Completed <= 1'b0;
      CrtWordData  <= '0;
      LineData     <= '0;
      Busy         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      LB_FirstWord <= 1'b0;
      unique case (state)
        IDLE: begin
          if (LB_Enable) begin
            M_ARADDR    <= {MissAddress[ADDR_W-1:2], 2'b00};
            LineAddress <= {MissAddress[ADDR_W-1:LOFF],
                            LOFF'(0)};
            idx         <= startIdx;
            cnt         <= '0;
            Error       <= 1'b0;
            Busy        <= 1'b1;
            abortReq    <= 1'b0;
            M_ARVALID   <= 1'b1;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (!LB_Enable) abortReq <= 1'b1;
          if (M_ARREADY) begin
            M_ARVALID <= 1'b0;
            state <= (abortReq || !LB_Enable) ? DRAIN : DATA;
          end
        end
        DATA, DRAIN: begin
          if (!live) state <= DRAIN;
          if (beat) begin
            LineData[{idx, 5'b00000} +: 32] <= M_RDATA;
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
            cnt <= cnt + 1'b1;
            if (beatErr) Error <= 1'b1;
            if (live && cnt == '0) begin
              CrtWordData  <= M_RDATA;
              LB_FirstWord <= 1'b1;
            end
            if (lastBeat) begin
              if (live) begin
                LB_Completed <= 1'b1;
                state        <= DONE;
              end else begin
                Busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
        end
        DONE: begin
          if (!LB_Enable) begin
            LB_Completed <= 1'b0;
            Busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_buffer.sv
// tb_line_fill_buffer: directed checks of the line fill buffer
// against a small AXI read slave with configurable stalls.
module tb_line_fill_buffer;

  localparam int W = 8;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            LB_Enable;
  logic [31:0]     MissAddress;
  logic [31:0]     LineAddress;
  logic            LB_FirstWord;
  logic [31:0]     CrtWordData;
  logic            LB_Completed;
  logic [32*W-1:0] LineData;
  logic            Busy;
  logic            Error;
  logic [31:0]     M_ARADDR;
  logic [7:0]      M_ARLEN;
  logic [2:0]      M_ARSIZE;
  logic [1:0]      M_ARBURST;
  logic            M_ARVALID;
  logic            M_ARREADY;
  logic [31:0]     M_RDATA;
  logic [1:0]      M_RRESP;
  logic            M_RLAST;
  logic            M_RVALID;
  logic            M_RREADY;

  line_fill_buffer #(.WORDS_PER_LINE(W), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .LB_Enable(LB_Enable),
    .MissAddress(MissAddress), .LineAddress(LineAddress),
    .LB_FirstWord(LB_FirstWord), .CrtWordData(CrtWordData),
    .LB_Completed(LB_Completed), .LineData(LineData),
    .Busy(Busy), .Error(Error),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN),
    .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge Clk) cyc++;

  int          arDelay = 0;
  logic        rGap = 1'b0;
  int          errBeat = 99;
  logic [31:0] dataBase = 32'h0;
  int          burstLeft = 0;
  int          sBeat = 0;
  int          arWaited = 0;
  logic        rPhase = 1'b0;
  logic        arHs;
  logic        rHs;

  // AXI read slave: handshakes seen at negedge, drives after posedge
  initial begin
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    M_RDATA   = 32'h0;
    M_RRESP   = 2'b00;
    M_RLAST   = 1'b0;
    forever begin
      @(negedge Clk);
      arHs = M_ARVALID && M_ARREADY;
      rHs  = M_RVALID && M_RREADY;
      @(posedge Clk);
      #1;
      if (Rst) begin
        burstLeft = 0;
        sBeat     = 0;
        arWaited  = 0;
        rPhase    = 1'b0;
        M_ARREADY = (arDelay == 0);
        M_RVALID  = 1'b0;
        M_RLAST   = 1'b0;
        M_RRESP   = 2'b00;
      end else begin
        if (arHs) begin
          burstLeft = W;
          sBeat     = 0;
          rPhase    = 1'b0;
        end
        if (!M_ARVALID || arHs) begin
          arWaited  = 0;
          M_ARREADY = (arDelay == 0);
        end else if (!M_ARREADY) begin
          if (arWaited >= arDelay) M_ARREADY = 1'b1;
          else arWaited++;
        end
        if (rHs) begin
          sBeat++;
          burstLeft--;
        end
        if (burstLeft > 0) begin
          rPhase   = rGap ? !rPhase : 1'b1;
          M_RVALID = rPhase;
          M_RDATA  = dataBase + 32'(sBeat);
          M_RRESP  = (sBeat == errBeat) ? 2'b10 : 2'b00;
          M_RLAST  = (sBeat == W - 1);
        end else begin
          M_RVALID = 1'b0;
          M_RLAST  = 1'b0;
          M_RRESP  = 2'b00;
        end
      end
    end
  end

  int          rBeats, firstRCyc, lastRCyc;
  int          fwCount, fwCyc;
  int          compCount, compCyc, compBeats;
  int          arCycles, arBad, busyFallCyc;
  logic [31:0] arAddr0;
  logic        prevComp = 1'b0;
  logic        prevBusy = 1'b0;

  // Event monitor sampled mid-cycle
  always @(negedge Clk) begin
    if (M_RVALID && M_RREADY) begin
      if (rBeats == 0) firstRCyc = cyc;
      rBeats++;
      lastRCyc = cyc;
    end
    if (LB_FirstWord) begin
      fwCount++;
      fwCyc = cyc;
    end
    if (LB_Completed && !prevComp) begin
      compCount++;
      compCyc = cyc;
      compBeats = rBeats;
    end
    if (M_ARVALID) begin
      if (arCycles == 0) arAddr0 = M_ARADDR;
      else if (M_ARADDR != arAddr0) arBad++;
      arCycles++;
    end
    if (prevBusy && !Busy) busyFallCyc = cyc;
    prevComp = LB_Completed;
    prevBusy = Busy;
  end

  task automatic clrMon();
    rBeats = 0; firstRCyc = 0; lastRCyc = 0;
    fwCount = 0; fwCyc = 0;
    compCount = 0; compCyc = 0; compBeats = 0;
    arCycles = 0; arBad = 0; busyFallCyc = 0;
    arAddr0 = 32'h0;
  endtask

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return LineData[i*32 +: 32];
  endfunction

  task automatic waitCompleted(input string tag, input int limit);
    int n = 0;
    while (LB_Completed !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(LB_Completed), 32'h1);
  endtask

  task automatic waitBeats(input string tag, input int k,
                           input int limit);
    int n = 0;
    while (rBeats < k && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(rBeats >= k), 32'h1);
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int n = 0;
    while (Busy !== 1'b0 && n < limit) begin
      step();
      n++;
    end
    check(tag, 32'(Busy), 32'h0);
  endtask

  int enCyc;

  initial begin
    Rst = 1'b1;
    LB_Enable = 1'b0;
    MissAddress = 32'h0;
    clrMon();
    repeat (3) step();

    check("rst_fw", 32'(LB_FirstWord), 0);
    check("rst_comp", 32'(LB_Completed), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_err", 32'(Error), 0);
    check("rst_arvalid", 32'(M_ARVALID), 0);
    check("rst_rready", 32'(M_RREADY), 0);
    check("rst_lineaddr", LineAddress, 0);
    check("rst_crt", CrtWordData, 0);
    check("rst_araddr", M_ARADDR, 0);
    check("rst_word0", word(0), 0);
    check("rst_word7", word(7), 0);
    check("arlen", 32'(M_ARLEN), 7);
    check("arsize", 32'(M_ARSIZE), 2);
    check("arburst", 32'(M_ARBURST), 2);

    Rst = 1'b0;
    step();

    // aligned miss, always-ready slave
    dataBase = 32'hA0;
    step();
    clrMon();
    MissAddress = 32'h0000_1000;
    LB_Enable = 1'b1;
    enCyc = cyc;
    step();
    check("t1_arvalid", 32'(M_ARVALID), 1);
    check("t1_araddr", M_ARADDR, 32'h1000);
    check("t1_busy", 32'(Busy), 1);
    check("t1_lineaddr", LineAddress, 32'h1000);
    waitCompleted("t1_done", 40);
    check("t1_fwcount", fwCount, 1);
    check("t1_r_lat", firstRCyc - enCyc, 2);
    check("t1_fw_lat", fwCyc - enCyc, 3);
    check("t1_comp_lat", compCyc - lastRCyc, 1);
    check("t1_crt", CrtWordData, 32'hA0);
    check("t1_err", 32'(Error), 0);
    for (int i = 0; i < W; i++)
      check($sformatf("t1_word%0d", i), word(i), 32'hA0 + 32'(i));
    LB_Enable = 1'b0;
    step();
    check("t1_comp_drop", 32'(LB_Completed), 0);
    check("t1_busy_drop", 32'(Busy), 0);
    check("t1_hold_word3", word(3), 32'hA3);
    check("t1_hold_lineaddr", LineAddress, 32'h1000);
    step();

    // critical word first from the last word of the line
    dataBase = 32'hB0;
    step();
    clrMon();
    MissAddress = 32'h0000_201C;
    LB_Enable = 1'b1;
    step();
    check("t2_araddr", M_ARADDR, 32'h201C);
    check("t2_lineaddr", LineAddress, 32'h2000);
    waitCompleted("t2_done", 40);
    check("t2_crt", CrtWordData, 32'hB0);
    check("t2_word7", word(7), 32'hB0);
    check("t2_word0", word(0), 32'hB1);
    check("t2_word3", word(3), 32'hB4);
    check("t2_word6", word(6), 32'hB7);
    check("t2_err", 32'(Error), 0);
    LB_Enable = 1'b0;
    step();
    step();

    // AR stall of 4 cycles, R valid every other cycle
    arDelay = 4;
    rGap = 1'b1;
    dataBase = 32'hC0;
    step();
    step();
    clrMon();
    MissAddress = 32'h0000_4008;
    LB_Enable = 1'b1;
    waitCompleted("t3_done", 80);
    check("t3_arcycles", arCycles, 5);
    check("t3_arstable", arBad, 0);
    check("t3_beats", rBeats, 8);
    check("t3_fwcount", fwCount, 1);
    check("t3_fw_lat", fwCyc - firstRCyc, 1);
    check("t3_comp_beats", compBeats, 8);
    check("t3_comp_lat", compCyc - lastRCyc, 1);
    check("t3_crt", CrtWordData, 32'hC0);
    check("t3_word2", word(2), 32'hC0);
    check("t3_word1", word(1), 32'hC7);
    LB_Enable = 1'b0;
    step();
    arDelay = 0;
    rGap = 1'b0;
    step();
    step();

    // bad RRESP on the 4th beat, then held handshake
    errBeat = 3;
    dataBase = 32'h90;
    step();
    clrMon();
    MissAddress = 32'h0000_8000;
    LB_Enable = 1'b1;
    waitCompleted("t4_done", 40);
    check("t4_err", 32'(Error), 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t4_comp_hold%0d", k), 32'(LB_Completed), 1);
    end
    LB_Enable = 1'b0;
    step();
    check("t4_comp_drop", 32'(LB_Completed), 0);
    check("t4_busy_drop", 32'(Busy), 0);
    check("t4_err_sticky", 32'(Error), 1);
    errBeat = 99;
    MissAddress = 32'h0000_3000;
    LB_Enable = 1'b1;
    step();
    check("t4_err_clear", 32'(Error), 0);
    check("t4_restart_busy", 32'(Busy), 1);
    check("t4_restart_araddr", M_ARADDR, 32'h3000);
    waitCompleted("t4_done2", 40);
    check("t4_err_final", 32'(Error), 0);
    LB_Enable = 1'b0;
    step();
    step();

    // abort after two beats
    dataBase = 32'hD0;
    step();
    clrMon();
    MissAddress = 32'h0000_5000;
    LB_Enable = 1'b1;
    waitBeats("t5_beats2", 2, 40);
    LB_Enable = 1'b0;
    waitIdle("t5_idle", 40);
    step();
    step();
    check("t5_beats", rBeats, 8);
    check("t5_compcount", compCount, 0);
    check("t5_fwcount", fwCount, 1);
    check("t5_busy_lat", busyFallCyc - lastRCyc, 1);
    check("t5_word0", word(0), 32'hD0);
    check("t5_word7", word(7), 32'hD7);

    // reset in the middle of a fill
    dataBase = 32'hE0;
    step();
    clrMon();
    MissAddress = 32'h0000_6000;
    LB_Enable = 1'b1;
    waitBeats("t6_beats5", 5, 40);
    Rst = 1'b1;
    step();
    check("t6_busy", 32'(Busy), 0);
    check("t6_fw", 32'(LB_FirstWord), 0);
    check("t6_comp", 32'(LB_Completed), 0);
    check("t6_err", 32'(Error), 0);
    check("t6_arvalid", 32'(M_ARVALID), 0);
    check("t6_rready", 32'(M_RREADY), 0);
    check("t6_lineaddr", LineAddress, 0);
    check("t6_crt", CrtWordData, 0);
    check("t6_araddr", M_ARADDR, 0);
    check("t6_word0", word(0), 0);
    Rst = 1'b0;
    LB_Enable = 1'b0;
    step();
    step();
    dataBase = 32'hF0;
    step();
    clrMon();
    MissAddress = 32'h0000_7004;
    LB_Enable = 1'b1;
    waitCompleted("t6_done", 40);
    check("t6_beats", rBeats, 8);
    check("t6_crt_new", CrtWordData, 32'hF0);
    check("t6_word1", word(1), 32'hF0);
    check("t6_word0", word(0), 32'hF7);
    check("t6_lineaddr_new", LineAddress, 32'h7000);
    check("t6_err_new", 32'(Error), 0);
    LB_Enable = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
